dca_lsu_inst_arbiter: RTL
=========================

Name: dca_lsu_inst_arbiter

Overview:
Shares one matrix LSU instruction port between two requesters: requester 0 issues load instructions and requester 1 issues store instructions. Grants are round-robin, and the block registers the granted instruction toward the LSU. It records the requester of every issued instruction in an in-order tag queue, so each LSU completion pulse is returned to the correct requester. It sits between the DCA step sequencer's load/store instruction outputs and the single matrix LSU.

Parameters:
BW_LSU_INST, `BW_DCA_MATRIX_LSU_INST, width of one LSU instruction
MAX_OUTSTANDING, 4, maximum instructions issued but not completed (held + in flight); power of two, >=2
BW_COUNT, $clog2(MAX_OUTSTANDING+1), outstanding counter width (localparam)

Ports:
clk  in  1  clock
rst  in  1  reset; synchronous, active-high
clear  in  1  synchronous flush, same effect as rst
enable  in  1  0 = no new grants; pending output handshake and done routing continue
req_valid  in  2  per requester: instruction offered (bit0 load, bit1 store)
req_ready  out  2  per requester: instruction accepted this cycle
req_inst  in  2*BW_LSU_INST  per-requester instructions; requester i at [i*BW_LSU_INST +: BW_LSU_INST]
req_done  out  2  one-cycle completion pulse to the owning requester
lsu_valid  out  1  instruction valid toward LSU
lsu_ready  in  1  LSU accepts instruction
lsu_inst  out  BW_LSU_INST  registered granted instruction
lsu_done  in  1  one-cycle pulse; LSU completes instructions strictly in issue order
busy  out  1  outstanding count != 0
err_spurious_done  out  1  sticky; lsu_done seen while tag queue empty

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset/clear values: lsu_valid=0, lsu_inst=0, req_ready=0, req_done=0, busy=0, err_spurious_done=0, priority pointer=0 (load first), tag queue empty, count=0.
- rst or clear mid-operation drops held and in-flight bookkeeping. Later lsu_done pulses then raise err_spurious_done; this is the owner's responsibility.
- Output holding register (hold_valid = lsu_valid). It is free when !lsu_valid, or when lsu_valid & lsu_ready this cycle.
- Grant condition: enable & free & (count - drain_now) < MAX_OUTSTANDING & any req_valid. drain_now = lsu_done & tag queue non-empty.
- Arbitration: if only one req_valid, grant it. If both, grant the requester at the priority pointer.
- After any grant, the pointer moves to the other requester. Strict alternation under continuous contention.
- req_ready is combinational: asserted only for the granted requester, in the same cycle as grant. req_valid must not depend on req_ready.
- Latency: grant in cycle N -> lsu_valid=1 with that instruction in cycle N+1. Back-to-back grants are allowed when lsu_ready=1 every cycle (throughput 1/cycle).
- lsu_inst and its owner tag stay stable while lsu_valid & !lsu_ready.
- Tag queue: depth MAX_OUTSTANDING, 1-bit entries. Push the owner tag when lsu_valid & lsu_ready. Pop when lsu_done & non-empty.
- Popping drives req_done[tag]=1 for one cycle, registered: done in cycle N -> req_done in cycle N+1.
- Simultaneous push and pop in the same cycle: both take effect; occupancy is unchanged.
- count = lsu_valid + queue occupancy. +1 on grant, -1 on drain_now; both in one cycle leaves it unchanged. busy = (count != 0).
- Full condition: count == MAX_OUTSTANDING blocks grants unless drain_now is asserted in the same cycle.
- Empty queue with lsu_done: ignored, no req_done, err_spurious_done set and held until rst/clear.
- enable=0: no grants and the pointer is frozen. The holding register may still hand off, and lsu_done is still routed.

Decomposition:
- Shared package dca_lsu_arb_pkg: requester index constants (REQ_LOAD=0, REQ_STORE=1), NUM_REQ=2, tag width.
- One natural sub-module: dca_lsu_tag_queue, a synchronous in-order 1-bit FIFO with push/pop/empty/full and occupancy output. The ERVP_FIFO library instance is also acceptable.

Test Plan:
- Single load: req_valid=01, inst=0xA5, lsu_ready=1 -> req_ready=01 in cycle 0; lsu_valid=1 with lsu_inst=0xA5 in cycle 1; lsu_done in cycle 5 -> req_done=01 in cycle 6; busy low from cycle 6.
- Contention: both valid continuously, lsu_ready=1, done 2 cycles after each issue -> grant order L,S,L,S; req_done pulses follow the same order.
- Backpressure/full: lsu_ready=1, no lsu_done, both valid -> exactly 4 grants, then req_ready=0. One lsu_done -> exactly one more grant in that same cycle.
- Stall: lsu_ready=0 for 3 cycles with lsu_valid=1 -> lsu_inst stable, no req_ready; lsu_ready=1 -> handoff, and the next grant occurs in that same cycle.
- Spurious done: lsu_done with nothing outstanding -> no req_done, err_spurious_done=1 until clear. clear mid-traffic -> all outputs return to reset values the next cycle.
- enable=0 with both valid -> no grants, the held instruction still hands off and pending done is routed. enable=1 -> grants resume from the frozen pointer.

Source files
------------

// File: rtl/dca_lsu_arb_pkg.sv
// Shared definitions for the LSU instruction arbiter: requester indices and owner tag type.
package dca_lsu_arb_pkg;

   localparam int BW_LSU_INST_DEFAULT = 8;

   localparam int NUM_REQ = 2;
   localparam int BW_TAG  = 1;

   typedef logic [BW_TAG-1:0] tag_t;

   localparam tag_t REQ_LOAD  = 1'b0;
   localparam tag_t REQ_STORE = 1'b1;

   // Converts an owner tag into the one-hot requester mask used for ready and done vectors.
   function automatic logic [NUM_REQ-1:0] tag_to_onehot(input tag_t tag);
      return (tag == REQ_STORE) ? 2'b10 : 2'b01;
   endfunction

endpackage

// File: rtl/dca_lsu_tag_queue.sv
// In-order FIFO of owner tags for instructions handed to the LSU and not yet completed.
module dca_lsu_tag_queue
    import dca_lsu_arb_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int BW_OCC = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  tag_t              push_tag,
    input  logic              pop,
    output tag_t              pop_tag,
    output logic              empty,
    output logic              full,
    output logic [BW_OCC-1:0] occupancy
);

    localparam int BW_PTR = $clog2(DEPTH);

    tag_t              mem [DEPTH];
    logic [BW_PTR-1:0] wr_ptr;
    logic [BW_PTR-1:0] rd_ptr;
    logic [BW_OCC-1:0] occ;
    logic              do_push;
    logic              do_pop;

    assign empty     = (occ == '0);
    assign full      = (occ == BW_OCC'(DEPTH));
    assign occupancy = occ;
    assign pop_tag   = mem[rd_ptr];

    // A push into a full queue is still legal when an entry leaves in the same cycle.
    assign do_push = push & (~full | pop);
    assign do_pop  = pop & ~empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= REQ_LOAD;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_tag;
                wr_ptr      <= wr_ptr + BW_PTR'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + BW_PTR'(1);
            end
            case ({do_push, do_pop})
                2'b10:   occ <= occ + BW_OCC'(1);
                2'b01:   occ <= occ - BW_OCC'(1);
                default: occ <= occ;
            endcase
        end
    end

endmodule

// File: rtl/dca_lsu_inst_arbiter.sv
// Round-robin arbiter sharing one matrix LSU instruction port between load and store requesters,
// with an in-order owner tag queue that routes LSU completion pulses back to their requester.
module dca_lsu_inst_arbiter
    import dca_lsu_arb_pkg::*;
#(
    parameter int BW_LSU_INST     = BW_LSU_INST_DEFAULT,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           clear,
    input  logic                           enable,
    input  logic [NUM_REQ-1:0]             req_valid,
    output logic [NUM_REQ-1:0]             req_ready,
    input  logic [NUM_REQ*BW_LSU_INST-1:0] req_inst,
    output logic [NUM_REQ-1:0]             req_done,
    output logic                           lsu_valid,
    input  logic                           lsu_ready,
    output logic [BW_LSU_INST-1:0]         lsu_inst,
    input  logic                           lsu_done,
    output logic                           busy,
    output logic                           err_spurious_done
);

    localparam int BW_COUNT = $clog2(MAX_OUTSTANDING + 1);

    logic                flush;
    logic                drain_now;
    logic                hold_free;
    logic                below_limit;
    logic                grant;
    tag_t                sel;
    tag_t                ptr;
    tag_t                hold_tag;
    tag_t                q_pop_tag;
    logic                q_empty;
    logic                q_full;
    logic [BW_COUNT-1:0] q_occ;
    logic [BW_COUNT-1:0] count;

    assign flush     = rst | clear;
    assign drain_now = lsu_done & ~q_empty;
    assign hold_free = ~lsu_valid | lsu_ready;

    // Outstanding work is the held instruction plus everything the LSU has accepted but not finished.
    assign count       = BW_COUNT'(lsu_valid) + q_occ;
    assign busy        = (count != '0);
    assign below_limit = (count - BW_COUNT'(drain_now)) < BW_COUNT'(MAX_OUTSTANDING);

    always_comb begin
        sel = REQ_LOAD;
        if (req_valid == 2'b11) begin
            sel = ptr;
        end else if (req_valid[REQ_STORE]) begin
            sel = REQ_STORE;
        end
    end

    assign grant     = ~flush & enable & hold_free & below_limit & (|req_valid);
    assign req_ready = grant ? tag_to_onehot(sel) : '0;

    always_ff @(posedge clk) begin
        if (flush) begin
            lsu_valid         <= 1'b0;
            lsu_inst          <= '0;
            hold_tag          <= REQ_LOAD;
            ptr               <= REQ_LOAD;
            req_done          <= '0;
            err_spurious_done <= 1'b0;
        end else begin
            req_done <= drain_now ? tag_to_onehot(q_pop_tag) : '0;
            if (lsu_done & q_empty) begin
                err_spurious_done <= 1'b1;
            end
            if (grant) begin
                lsu_valid <= 1'b1;
                lsu_inst  <= (sel == REQ_STORE) ? req_inst[NUM_REQ*BW_LSU_INST-1:BW_LSU_INST]
                                                : req_inst[BW_LSU_INST-1:0];
                hold_tag  <= sel;
                ptr       <= ~sel;
            end else if (lsu_ready) begin
                lsu_valid <= 1'b0;
            end
        end
    end

    dca_lsu_tag_queue #(
        .DEPTH  (MAX_OUTSTANDING),
        .BW_OCC (BW_COUNT)
    ) u_tag_queue (
        .clk       (clk),
        .rst       (flush),
        .push      (lsu_valid & lsu_ready),
        .push_tag  (hold_tag),
        .pop       (drain_now),
        .pop_tag   (q_pop_tag),
        .empty     (q_empty),
        .full      (q_full),
        .occupancy (q_occ)
    );

    logic unused_q_full;
    assign unused_q_full = q_full;

endmodule
